// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_pkg
//  Brief    : Shared types and constants for the board reset/timebase block.
//  Revision : 1.0 - initial release
// ============================================================================
package board_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        PRESS = 2'd2
    } rst_state_t;

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_BTN = 2'b10;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tick_divider
//  Brief    : Free-running divider producing a 1-cycle tick and a square wave.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_divider
    import board_pkg::*;
#(
    parameter int TICK_DIV = 60000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o,
    output logic tick_sq_o
);

    localparam int               CNT_W    = cnt_width(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic             tick_sq_q;
    logic             tick_sq_d;

    generate
        if (TICK_DIV < 2) begin : g_bad_tick_div
            $error("tick_divider: TICK_DIV must be >= 2");
        end
    endgenerate

    always_comb begin
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d    = (cnt_q == CNT_LAST);
        tick_sq_d = tick_sq_q ^ tick_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            tick_sq_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            tick_sq_q <= tick_sq_d;
        end
    end

    assign tick_o    = tick_q;
    assign tick_sq_o = tick_sq_q;

endmodule
`default_nettype wire

// File: rtl/board_reset_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : board_reset_tick_gen
//  Brief    : Board timebase plus reset sequencer with debounced button combo.
//  Revision : 1.0 - initial release
// ============================================================================
module board_reset_tick_gen
    import board_pkg::*;
#(
    parameter int               TICK_DIV       = 60000,
    parameter int               HOLD_TICKS     = 4,
    parameter int               DEBOUNCE_TICKS = 2,
    parameter int               BTN_W          = 21,
    parameter logic [BTN_W-1:0] COMBO_MASK     = BTN_W'('h10009)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [BTN_W-1:0] btn,
    output logic             tick,
    output logic             tick_sq,
    output logic             sys_rst_n,
    output logic [1:0]       rst_cause
);

    localparam int               HOLD_W    = cnt_width(HOLD_TICKS - 1);
    localparam int               DEB_W     = cnt_width(DEBOUNCE_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_TICKS);
    localparam logic             MASK_EN   = (COMBO_MASK != '0);

    generate
        if (HOLD_TICKS < 1) begin : g_bad_hold
            $error("board_reset_tick_gen: HOLD_TICKS must be >= 1");
        end
        if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
            $error("board_reset_tick_gen: DEBOUNCE_TICKS must be >= 1");
        end
        if (BTN_W < 1) begin : g_bad_btn_w
            $error("board_reset_tick_gen: BTN_W must be >= 1");
        end
    endgenerate

    logic              w_tick;
    logic              w_tick_sq;
    logic              w_combo;
    logic              w_pressed;

    logic [BTN_W-1:0]  btn_meta_q;
    logic [BTN_W-1:0]  btn_sync_q;
    rst_state_t        state_q;
    rst_state_t        state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  deb_cnt_d;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;
    logic              sys_rst_n_q;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk       (clk),
        .rst_n     (nrst),
        .tick_o    (w_tick),
        .tick_sq_o (w_tick_sq)
    );

    // Buttons outside the mask are forced high so only masked ones matter.
    assign w_combo = MASK_EN & (&(btn_sync_q | ~COMBO_MASK));

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        cause_d    = cause_q;
        w_pressed  = 1'b0;

        if (w_tick) begin
            if (!w_combo) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q != DEB_MAX) begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
            // The sample taken on this tick already counts towards pressed.
            w_pressed = (deb_cnt_d == DEB_MAX);

            unique case (state_q)
                HOLD: begin
                    if (w_pressed) begin
                        state_d    = PRESS;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = RUN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (w_pressed) begin
                        state_d = PRESS;
                        cause_d = CAUSE_BTN;
                    end
                end
                PRESS: begin
                    hold_cnt_d = '0;
                    if (!w_combo) begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            cause_q     <= CAUSE_POR;
            sys_rst_n_q <= 1'b0;
        end else begin
            btn_meta_q  <= btn;
            btn_sync_q  <= btn_meta_q;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            cause_q     <= cause_d;
            sys_rst_n_q <= (state_d == RUN);
        end
    end

    assign tick      = w_tick;
    assign tick_sq   = w_tick_sq;
    assign sys_rst_n = sys_rst_n_q;
    assign rst_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_board_reset_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_reset_tick_gen
//  Brief    : Scoreboard bench with a tick-level reference model, two builds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_reset_tick_gen;

    localparam int            TD   = 4;
    localparam int            HT   = 3;
    localparam int            DT   = 2;
    localparam int            BW   = 4;
    localparam logic [BW-1:0] MASK = 4'b1001;

    localparam int M_HOLD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PRESS = 2;

    logic          clk  = 1'b0;
    logic          nrst = 1'b0;
    logic [BW-1:0] btn  = '0;

    logic       tick,  tick_sq,  srst;
    logic       tick2, tick_sq2, srst2;
    logic [1:0] cause, cause2;

    always #5 clk = ~clk;

    board_reset_tick_gen #(
        .TICK_DIV(TD), .HOLD_TICKS(HT), .DEBOUNCE_TICKS(DT), .BTN_W(BW), .COMBO_MASK(MASK)
    ) dut (
        .clk(clk), .nrst(nrst), .btn(btn), .tick(tick), .tick_sq(tick_sq),
        .sys_rst_n(srst), .rst_cause(cause)
    );

    board_reset_tick_gen #(
        .TICK_DIV(TD), .HOLD_TICKS(HT), .DEBOUNCE_TICKS(DT), .BTN_W(BW), .COMBO_MASK(4'b0000)
    ) dut_nomask (
        .clk(clk), .nrst(nrst), .btn(btn), .tick(tick2), .tick_sq(tick_sq2),
        .sys_rst_n(srst2), .rst_cause(cause2)
    );

    typedef struct packed {
        logic       tick;
        logic       sq;
        logic       srst;
        logic [1:0] cause;
        logic       srst2;
        logic [1:0] cause2;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: edges since release, consecutive combo ticks,
    // completed hold ticks, current phase and reported cause.
    int            m_edge;
    int            m_run;
    int            m_held;
    int            m_mode;
    logic [1:0]    m_cause;
    logic [BW-1:0] m_log[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic combo_of(input logic [BW-1:0] b);
        return &(b | ~MASK);
    endfunction

    task automatic model_reset();
        m_edge  = 0;
        m_run   = 0;
        m_held  = 0;
        m_mode  = M_HOLD;
        m_cause = 2'b01;
        m_log.delete();
    endtask

    task automatic model_edge(output exp_t x);
        logic seen;
        m_edge++;
        m_log.push_back(btn);
        // Two-flop synchroniser: the value seen now was on the pins two edges ago.
        seen = (m_edge >= 3) ? combo_of(m_log[m_edge-3]) : 1'b0;
        if (m_edge > 1 && ((m_edge - 1) % TD) == 0) begin
            m_run = seen ? m_run + 1 : 0;
            case (m_mode)
                M_HOLD: begin
                    if (m_run >= DT) m_mode = M_PRESS;
                    else begin
                        m_held++;
                        if (m_held == HT) m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (m_run >= DT) begin
                        m_mode  = M_PRESS;
                        m_cause = 2'b10;
                    end
                end
                default: begin
                    if (!seen) begin
                        m_mode = M_HOLD;
                        m_held = 0;
                    end
                end
            endcase
        end
        x.tick   = ((m_edge % TD) == 0);
        x.sq     = ((((m_edge - 1) / TD) % 2) == 1);
        x.srst   = (m_mode == M_RUN);
        x.cause  = m_cause;
        x.srst2  = (m_edge >= 1 + HT * TD);
        x.cause2 = 2'b01;
    endtask

    // Issue one clock with the current inputs; entered and left at a negedge.
    task automatic step();
        exp_t x;
        if (nrst) begin
            model_edge(x);
        end else begin
            x        = '0;
            x.cause  = 2'b01;
            x.cause2 = 2'b01;
        end
        sb_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_reset(input int cycles);
        #2 nrst = 1'b0;
        #1;
        check("async_main",   {3'b000, tick,  tick_sq,  srst,  cause},  8'b0000_0001);
        check("async_nomask", {3'b000, tick2, tick_sq2, srst2, cause2}, 8'b0000_0001);
        model_reset();
        for (int i = 0; i < cycles; i++) step();
        nrst = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check("main",   {3'b000, tick,  tick_sq,  srst,  cause},
                                {3'b000, x.tick, x.sq, x.srst, x.cause});
                check("nomask", {3'b000, tick2, tick_sq2, srst2, cause2},
                                {3'b000, x.tick, x.sq, x.srst2, x.cause2});
            end
        end
    end

    initial begin : stimulus
        model_reset();
        @(negedge clk);
        repeat (3) step();
        nrst = 1'b1;

        // Power-on sequence.
        repeat (20) step();

        // Combo in RUN, held, then released.
        btn = MASK;
        repeat (40) step();
        btn = '0;
        repeat (30) step();

        // Partial combo and a single-tick combo pulse.
        btn = 4'b1000;
        repeat (24) step();
        btn = MASK;
        repeat (TD) step();
        btn = '0;
        repeat (20) step();

        // Reset mid-count in RUN.
        repeat (3) step();
        async_reset(2);
        repeat (20) step();

        // Reset during PRESS with the combo held through release.
        btn = MASK;
        repeat (20) step();
        async_reset(2);
        repeat (30) step();
        btn = '0;
        repeat (30) step();

        // Combo lands on the hold-completion tick.
        async_reset(1);
        repeat (4) step();
        btn = MASK;
        repeat (16) step();
        btn = '0;
        repeat (30) step();

        // Randomised segments.
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 5))
                0:       btn = '0;
                1:       btn = MASK;
                2:       btn = 4'b1000;
                3:       btn = BW'($urandom);
                4:       btn = '1;
                default: btn = MASK | BW'($urandom);
            endcase
            repeat ($urandom_range(1, 24)) step();
            if ($urandom_range(0, 15) == 0) async_reset(int'($urandom_range(1, 3)));
        end
        btn = '0;
        repeat (30) step();

        check("drain", 8'(sb_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
